lap_record_ctrl: RTL

- Control stage directly upstream of the 5-entry lap stack (12-bit count in; read/write pulses; 12-bit top-of-stack out).
- Turns raw stopwatch buttons into a running 12-bit tick count and single-cycle push/pop pulses.
- Tracks stack occupancy and latches recalled entries for the display stage.
- The stack has no clear port, so clear is done by draining it with pop pulses.

---
 rtl/lap_record_pkg.sv | 40 ++++
 rtl/lap_record_ctrl_btn_cond.sv | 79 +++++++
 rtl/lap_record_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/lap_record_pkg.sv
// lap_record_pkg: shared types and constants for the lap-record controller.
//
// Contents:
//   LAP_DEPTH - capacity of the downstream lap stack (shared with the stack)
//   LAP_CNT_W - width of the running count / stack data
//   count_t   - 12-bit count type
//   state_t   - controller FSM states
//   sat_step  - helper: depth after an optional push/pop, clamped to 0..max
`timescale 1ns/1ps

package lap_record_pkg;

    localparam int LAP_DEPTH = 5;
    localparam int LAP_CNT_W = 12;

    typedef logic [11:0] count_t;

    typedef enum logic [1:0] {
        LIVE   = 2'd0,
        RECALL = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Occupancy after a push or pop. Callers only push when not full and only
    // pop when not empty; the clamp keeps the register in range regardless.
    function automatic logic [2:0] sat_step(input logic [2:0] cur,
                                            input logic       push,
                                            input logic       pop,
                                            input logic [2:0] max);
        logic [2:0] nxt;
        nxt = cur;
        if (push && (cur != max)) begin
            nxt = cur + 3'd1;
        end else if (pop && (cur != 3'd0)) begin
            nxt = cur - 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lap_record_ctrl_btn_cond.sv
// btn_cond: conditions one raw asynchronous button into a single-cycle event.
//
// Path: 2-FF synchronizer -> optional debounce filter -> registered rising-edge
// detect. Without the filter the event pulse appears 3 clk cycles after the
// raw edge; with the filter it appears 3+DB_CYCLES cycles after.
//
// Build option: define LAP_RECORD_DEBOUNCE_EN to insert the debounce filter
// (DB_CYCLES consecutive equal samples before the filtered level changes).
//
// Ports:
//   clk  - system clock
//   nrst - asynchronous active-low reset
//   raw  - raw asynchronous button level
//   evt  - one-cycle pulse on each accepted press
`timescale 1ns/1ps

module btn_cond #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic raw,
    output logic evt
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef LAP_RECORD_DEBOUNCE_EN
    localparam int DB_W = $clog2(DB_CYCLES + 1);

    logic [DB_W-1:0] db_cnt;
    logic            filt;

    // Counts consecutive samples that disagree with the filtered level; any
    // agreeing sample restarts the count, so short glitches never get through.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            db_cnt <= '0;
            filt   <= 1'b0;
        end else if (sync2 == filt) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
            db_cnt <= '0;
            filt   <= sync2;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    // The event is registered so downstream logic sees a clean flop output.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            level_d <= 1'b0;
            evt     <= 1'b0;
        end else begin
            level_d <= level;
            evt     <= level & ~level_d;
        end
    end

endmodule

// File: rtl/lap_record_ctrl.sv
// lap_record_ctrl: stopwatch control stage in front of the 5-entry lap stack.
//
// Turns the four raw buttons into events, runs a prescaled 12-bit tick count,
// issues one-cycle push (write) / pop (read) pulses to the stack, tracks stack
// occupancy, and latches recalled laps for the display. The stack has no clear
// port, so clear drains it with consecutive pops.
//
// Build option: LAP_RECORD_DEBOUNCE_EN enables a DB_CYCLES debounce filter in
// each button conditioner.
//
// Ports:
//   clk, nrst         - clock, asynchronous active-low reset
//   start_btn         - raw start/stop button (toggles running)
//   lap_btn           - raw lap button (push count)
//   recall_btn        - raw recall button (pop and display)
//   clear_btn         - raw clear button (stop, zero, drain stack)
//   mem_out           - stack top-of-stack
//   count             - running count, feeds stack data input
//   write, read       - one-cycle push / pop pulses, never both high
//   disp_val          - display value (live count or recalled lap)
//   disp_recall       - 1 while disp_val shows a recalled lap
//   depth             - stack occupancy 0..DEPTH
//   full, empty       - depth==DEPTH / depth==0
//   running           - count is advancing
//   fsm_state         - current controller state (state_t encoding)
//
// Handshake: there is no back-pressure. write/read are single-cycle strobes;
// the stack acts on the rising clk edge that ends the strobe cycle, and it
// presents the new top-of-stack on mem_out in the following cycle.
`timescale 1ns/1ps

module lap_record_ctrl
    import lap_record_pkg::*;
#(
    parameter int DEPTH       = LAP_DEPTH,
    parameter int CNT_W       = LAP_CNT_W,
    parameter int TICK_DIV    = 100,
    parameter int SHOW_CYCLES = 200,
    parameter int DB_CYCLES   = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start_btn,
    input  logic             lap_btn,
    input  logic             recall_btn,
    input  logic             clear_btn,
    input  logic [CNT_W-1:0] mem_out,
    output logic [CNT_W-1:0] count,
    output logic             write,
    output logic             read,
    output logic [CNT_W-1:0] disp_val,
    output logic             disp_recall,
    output logic [2:0]       depth,
    output logic             full,
    output logic             empty,
    output logic             running,
    output logic [1:0]       fsm_state
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int TMR_W = $clog2(SHOW_CYCLES + 1);

    logic start_evt;
    logic lap_evt;
    logic recall_evt;
    logic clear_evt;

    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_start  (.clk(clk), .nrst(nrst), .raw(start_btn),  .evt(start_evt));
    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_lap    (.clk(clk), .nrst(nrst), .raw(lap_btn),    .evt(lap_evt));
    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_recall (.clk(clk), .nrst(nrst), .raw(recall_btn), .evt(recall_evt));
    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_clear  (.clk(clk), .nrst(nrst), .raw(clear_btn),  .evt(clear_evt));

    state_t             state_q, state_d;
    logic [2:0]         depth_q, depth_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   recall_q;
    logic [CNT_W-1:0]   count_q;
    logic [PRE_W-1:0]   presc_q;
    logic               running_q;
    logic               latch;
    logic               tick;

    logic in_drain;
    logic do_clear;
    logic do_lap;
    logic do_recall;
    logic do_start;
    logic full_i;
    logic empty_i;

    // Priority clear > lap > recall > start: a higher event in the same cycle
    // drops every lower one, even when the higher one is itself ignored
    // (e.g. lap while full still swallows a simultaneous recall).
    assign in_drain  = (state_q == DRAIN);
    assign do_clear  = clear_evt & ~in_drain;
    assign do_lap    = lap_evt & ~clear_evt & ~in_drain;
    assign do_recall = recall_evt & ~lap_evt & ~clear_evt & ~in_drain;
    assign do_start  = start_evt & ~recall_evt & ~lap_evt & ~clear_evt & ~in_drain;

    assign full_i  = (depth_q == 3'(DEPTH));
    assign empty_i = (depth_q == 3'd0);

    assign tick = running_q && (presc_q == PRE_W'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        tmr_d   = tmr_q;
        write   = 1'b0;
        read    = 1'b0;
        latch   = 1'b0;
        case (state_q)
            LIVE, RECALL: begin
                // Hold timer only runs while a recalled value is shown.
                if (state_q == RECALL) begin
                    if (tmr_q == '0) begin
                        state_d = LIVE;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                if (do_clear) begin
                    state_d = DRAIN;
                end else if (do_lap) begin
                    if (!full_i) begin
                        write   = 1'b1;
                        depth_d = sat_step(depth_q, 1'b1, 1'b0, 3'(DEPTH));
                    end
                end else if (do_recall && !empty_i) begin
                    read    = 1'b1;
                    latch   = 1'b1;
                    depth_d = sat_step(depth_q, 1'b0, 1'b1, 3'(DEPTH));
                    tmr_d   = TMR_W'(SHOW_CYCLES - 1);
                    state_d = RECALL;
                end
            end
            DRAIN: begin
                // One pop per cycle until the stack is empty, then one final
                // cycle here before returning to LIVE.
                if (!empty_i) begin
                    read    = 1'b1;
                    depth_d = sat_step(depth_q, 1'b0, 1'b1, 3'(DEPTH));
                end else begin
                    state_d = LIVE;
                end
            end
            default: begin
                state_d = LIVE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= LIVE;
            depth_q  <= 3'd0;
            tmr_q    <= '0;
            recall_q <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            tmr_q   <= tmr_d;
            if (latch) begin
                recall_q <= mem_out;
            end
        end
    end

    // Clear zeroes the timebase on the same edge that enters DRAIN; running
    // is then 0, so nothing advances until start is pressed again.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            running_q <= 1'b0;
            presc_q   <= '0;
            count_q   <= '0;
        end else if (do_clear) begin
            running_q <= 1'b0;
            presc_q   <= '0;
            count_q   <= '0;
        end else begin
            if (do_start) begin
                running_q <= ~running_q;
            end
            if (tick) begin
                presc_q <= '0;
                count_q <= count_q + 1'b1;
            end else if (running_q) begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    assign count       = count_q;
    assign running     = running_q;
    assign depth       = depth_q;
    assign full        = full_i;
    assign empty       = empty_i;
    assign disp_recall = (state_q == RECALL);
    assign disp_val    = (state_q == RECALL) ? recall_q : count_q;
    assign fsm_state   = state_q;

endmodule
